// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the UART word receiver.
//   rx_state_t  : bit-level FSM state encoding (plain localparams for legacy tools)
//   SYNC_STAGES : depth of the RxD synchroniser
//   nbytes()    : number of UART bytes needed to fill a word
// Optional feature macro: UART_WORD_RX_PARITY_EN (adds the parity state).
package uart_word_rx_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle     = 3'd0;
  localparam rx_state_t StStart    = 3'd1;
  localparam rx_state_t StData     = 3'd2;
`ifdef UART_WORD_RX_PARITY_EN
  localparam rx_state_t StParity   = 3'd3;
`endif
  localparam rx_state_t StStop     = 3'd4;
  localparam rx_state_t StWaitHigh = 3'd5;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned nbytes(input int unsigned width, input int unsigned bits);
    return (width + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// Word-side bus of the UART word receiver.
//   master : driven by the receiver (word_out, word_valid, frame_err, overrun, busy
//            and parity_err when UART_WORD_RX_PARITY_EN is defined); samples word_ready
//   slave  : the consumer view of the same signals
interface uart_word_rx_if #(
  parameter int unsigned WORD_WIDTH = 38
);
  logic [WORD_WIDTH-1:0] word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;
`ifdef UART_WORD_RX_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output word_out, word_valid, frame_err, overrun, busy,
`ifdef UART_WORD_RX_PARITY_EN
    output parity_err,
`endif
    input  word_ready
  );

  modport slave (
    input  word_out, word_valid, frame_err, overrun, busy,
`ifdef UART_WORD_RX_PARITY_EN
    input  parity_err,
`endif
    output word_ready
  );
endinterface

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: RxD synchroniser plus bit-timing FSM.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   rxd         : raw serial line, idle high
//   data        : last received byte (valid alongside byte_valid)
//   byte_valid  : 1-cycle pulse, byte accepted (good stop, good parity)
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   parity_err  : 1-cycle pulse, even parity mismatch (UART_WORD_RX_PARITY_EN only)
//   busy        : high from start-bit detect until the stop-bit sample
module uart_rx_byte
  import uart_word_rx_pkg::*;
#(
  parameter int unsigned BITS         = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  output logic [BITS-1:0] data,
  output logic            byte_valid,
  output logic            frame_err,
`ifdef UART_WORD_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;

  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tick;
`ifdef UART_WORD_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            pbad_q, pbad_d;
`endif

  assign rx   = sync_q[SYNC_STAGES-1];
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      // The line is only ever high on entry to idle, so a low level is the falling edge.
      StIdle: begin
        if (!rx) begin
          state_d = StStart;
          cnt_d   = HalfBit;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = FullBit;
            bit_d   = '0;
`ifdef UART_WORD_RX_PARITY_EN
            pbad_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {rx, shift_q[BITS-1:1]};
          cnt_d   = FullBit;
          if (bit_q == LastBit) begin
`ifdef UART_WORD_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef UART_WORD_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          // Even parity: data ones plus parity bit must be even.
          pbad_d  = rx ^ (^shift_q);
          perr_d  = rx ^ (^shift_q);
          state_d = StStop;
          cnt_d   = FullBit;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (rx) begin
            state_d = StIdle;
`ifdef UART_WORD_RX_PARITY_EN
            valid_d = !pbad_q;
`else
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitHigh: begin
        if (rx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_WORD_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  // shift_q does not move outside data states, so it is stable during the byte_valid pulse.
  assign data       = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
`ifdef UART_WORD_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
  assign busy       = (state_q != StIdle) && (state_q != StWaitHigh);

endmodule

// File: rtl/uart_word_rx.sv
// Host-side UART receiver packing consecutive bytes, LSB byte first, into words.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   RxD      : serial line, idle high, asynchronous to clk
//   bus      : uart_word_rx_if.master (word_out/word_valid/word_ready handshake,
//              frame_err, overrun, busy, and parity_err when enabled)
// Optional feature macro: UART_WORD_RX_PARITY_EN (even parity bit after the data bits).
// Needs at least two bytes per word.
module uart_word_rx
  import uart_word_rx_pkg::*;
#(
  parameter int unsigned BITS         = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned WORD_WIDTH   = 38,
  parameter int unsigned GAP_BITS     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RxD,
  uart_word_rx_if.master bus
);

  localparam int unsigned NBYTES    = nbytes(WORD_WIDTH, BITS);
  localparam int unsigned IdxW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned AccW      = (NBYTES > 1) ? (NBYTES - 1) * BITS : BITS;
  localparam int unsigned GapCycles = (GAP_BITS == 0) ? 1 : GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GapW      = $clog2(GapCycles + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);

  logic [BITS-1:0] rx_data;
  logic            rx_valid;
  logic            rx_busy;

  logic [IdxW-1:0]       idx_q, idx_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [GapW-1:0]       gap_q, gap_d;

  uart_rx_byte #(
    .BITS         (BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .rxd        (RxD),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (bus.frame_err),
`ifdef UART_WORD_RX_PARITY_EN
    .parity_err (bus.parity_err),
`endif
    .busy       (rx_busy)
  );

  always_comb begin
    idx_d     = idx_q;
    acc_d     = acc_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    gap_d     = gap_q;

    if (valid_q && bus.word_ready) valid_d = 1'b0;

    if (rx_valid) begin
      gap_d = '0;
      if (idx_q == LastIdx) begin
        idx_d = '0;
        // Load is allowed when the buffer drains in this same cycle.
        if (!valid_q || bus.word_ready) begin
          word_d  = WORD_WIDTH'({rx_data, acc_q});
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + IdxW'(1);
        for (int i = 0; i < int'(NBYTES) - 1; i++) begin
          if (idx_q == IdxW'(i)) acc_d[i*BITS +: BITS] = rx_data;
        end
      end
    end else if (rx_busy || (idx_q == '0)) begin
      gap_d = '0;
    end else if (GAP_BITS != 0) begin
      // Line idle too long mid-word: drop the partial word.
      if (gap_q == GapLast) begin
        idx_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      acc_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = rx_busy;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: the stimulus side feeds a byte-level reference model
// that pushes expected words; a negedge monitor pops them on every word transfer.
module tb_uart_word_rx;

  localparam int unsigned BITS = 8;
  localparam int unsigned CPB  = 16;
  localparam int unsigned WW   = 38;
  localparam int unsigned GAP  = 32;
  localparam int unsigned NB   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RxD = 1'b1;

  uart_word_rx_if #(.WORD_WIDTH(WW)) bus ();

  uart_word_rx #(
    .BITS         (BITS),
    .CLKS_PER_BIT (CPB),
    .WORD_WIDTH   (WW),
    .GAP_BITS     (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .RxD (RxD),
    .bus (bus)
  );

  always #4 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WW-1:0] exp_q[$];
  logic [7:0]    part_q[$];
  int exp_ferr = 0, got_ferr = 0;
  int exp_ovr  = 0, got_ovr  = 0;
  int exp_perr = 0, got_perr = 0;
  bit rand_ready = 1'b0;

  logic [WW-1:0] prev_word;
  bit            prev_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference model: a word is the first NB accepted bytes, byte i at bit 8*i, truncated.
  task automatic model_good_byte(input logic [7:0] b);
    logic [63:0] w;
    part_q.push_back(b);
    if (part_q.size() == NB) begin
      w = 64'd0;
      for (int i = 0; i < int'(NB); i++) w = w | (64'(part_q[i]) << (8 * i));
      part_q.delete();
      if (exp_q.size() != 0) exp_ovr++;
      else exp_q.push_back(w[WW-1:0]);
    end
  endtask

  task automatic drive_bit(input logic b);
    RxD = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_flip);
    bit bad_par;
    bad_par = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < int'(BITS); i++) drive_bit(b[i]);
`ifdef UART_WORD_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
    bad_par = par_flip;
    if (par_flip) exp_perr++;
`else
    if (par_flip) bad_par = 1'b0;
`endif
    // Update the model before the stop bit so expectations precede the DUT's output.
    if (!stop) exp_ferr++;
    else if (!bad_par) model_good_byte(b);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [39:0] w);
    for (int i = 0; i < int'(NB); i++) send_frame(w[8*i +: 8], 1'b1, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
    if (n > int'(GAP)) part_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RxD = 1'b1;
    exp_q.delete();
    part_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("reset_word_valid", 64'(bus.word_valid), 64'd0);
    check("reset_word_out", 64'(bus.word_out), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_pulses", 64'({bus.frame_err, bus.overrun}), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_count"}, 64'(got_ferr), 64'(exp_ferr));
    check({tag, "_overrun_count"}, 64'(got_ovr), 64'(exp_ovr));
`ifdef UART_WORD_RX_PARITY_EN
    check({tag, "_parity_err_count"}, 64'(got_perr), 64'(exp_perr));
`endif
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.word_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.frame_err) got_ferr++;
      if (bus.overrun) got_ovr++;
`ifdef UART_WORD_RX_PARITY_EN
      if (bus.parity_err) got_perr++;
`endif
      if (prev_hold) begin
        check("hold_valid", 64'(bus.word_valid), 64'd1);
        check("hold_stable", 64'(bus.word_out), 64'(prev_word));
      end
      if (bus.word_valid && bus.word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%0h want=none", bus.word_out);
        end else begin
          check("word", 64'(bus.word_out), 64'(exp_q.pop_front()));
        end
      end
      prev_hold = bus.word_valid && !bus.word_ready;
      prev_word = bus.word_out;
    end
  end

  initial begin
    logic [7:0] b;
    bus.word_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    idle_bits(2);

    // 1: one full word back to back
    send_word(40'h3F67452301);
    wait_drain("t1_drain");
    check_counts("t1");

    // 2: short low glitch is ignored
    RxD = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t2_busy_during_start", 64'(bus.busy), 64'd1);
    RxD = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t2_busy_after_glitch", 64'(bus.busy), 64'd0);
    idle_bits(2);
    check_counts("t2");

    // 3: bad stop bit, then a good word
    send_frame(8'hA5, 1'b0, 1'b0);
    send_word(40'h3F67452301 ^ 40'h1122334455);
    wait_drain("t3_drain");
    check_counts("t3");

    // 4: consumer stalled across two words
    bus.word_ready = 1'b0;
    send_word(40'h00_DE_AD_BE_EF);
    send_word(40'h12_34_56_78_9A);
    repeat (8) @(posedge clk);
    #1;
    check("t4_valid_held", 64'(bus.word_valid), 64'd1);
    if (exp_q.size() != 0) check("t4_first_word_kept", 64'(bus.word_out), 64'(exp_q[0]));
    check_counts("t4");
    bus.word_ready = 1'b1;
    wait_drain("t4_drain");

    // 5: partial word discarded after a long gap
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'hBB, 1'b1, 1'b0);
    idle_bits(40);
    send_word(40'h3F67452301);
    wait_drain("t5_drain");
    check_counts("t5");

    // 6: reset in the middle of the third byte
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    check("t6_busy_mid_frame", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    RxD = 1'b1;
    part_q.delete();
    #1;
    check("t6_busy_in_reset", 64'(bus.busy), 64'd0);
    check("t6_valid_in_reset", 64'(bus.word_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(2);
    send_word(40'hC0_FF_EE_12_34);
    wait_drain("t6_drain");
    check_counts("t6");

`ifdef UART_WORD_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    send_word(40'h05_06_07_08_09);
    wait_drain("par_drain");
    check_counts("par");
`endif

    // Random words with sporadic framing errors, idle gaps and a jittery consumer.
    rand_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < int'(NB); k++) begin
        if ($urandom_range(0, 7) == 0) send_frame(8'($urandom), 1'b0, 1'b0);
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        if ($urandom_range(0, 3) == 0) idle_bits(int'($urandom_range(1, 4)));
      end
    end
    repeat (4) @(posedge clk);
    rand_ready = 1'b0;
    #2;
    bus.word_ready = 1'b1;
    wait_drain("rand_drain");
    check_counts("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
